// File: rtl/audio_dac_sequencer.sv
// Stereo DAC playback sequencer: sample-pair FIFO, tick-paced release, click-free gain ramps.
// Define AUDIO_DAC_SEQ_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module audio_dac_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TICK_DIV   = 642,
    parameter int unsigned RAMP_STEP  = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    output logic [15:0] dac_left,
    output logic [15:0] dac_right,
    output logic        dac_n_reset,
    output logic        sample_tick,
    output logic [1:0]  state,
`ifdef AUDIO_DAC_SEQ_UNDERRUN_CNT_EN
    output logic [15:0] underrun_count,
`endif
    output logic        underrun
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFadeIn  = 2'd1,
        StRun     = 2'd2,
        StFadeOut = 2'd3
    } state_e;

    state_e         state_q;
    logic [TW-1:0]  tick_cnt_q;
    logic [8:0]     gain_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [15:0]    fifo_l_q [FIFO_DEPTH];
    logic [15:0]    fifo_r_q [FIFO_DEPTH];
    logic [15:0]    cur_l_q;
    logic [15:0]    cur_r_q;
    logic [15:0]    dac_l_q;
    logic [15:0]    dac_r_q;
    logic           dac_upd_q;
    logic           dac_n_reset_q;
    logic           underrun_q;

    logic              tick;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              to_idle;
    logic              urun_hit;
    logic [9:0]        gain_sum;
    logic [8:0]        gain_up;
    logic [8:0]        gain_dn;
    logic signed [25:0] prod_l;
    logic signed [25:0] prod_r;
    logic              unused_prod;

    assign sample_tick = n_reset && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick        = sample_tick;
    assign fifo_empty  = (count_q == '0);
    assign in_ready    = n_reset && (count_q != CW'(FIFO_DEPTH));
    // Pushes while idle are acknowledged but dropped so the mixer never stalls.
    assign push        = in_valid && in_ready && (state_q != StIdle);
    assign pop         = tick && (state_q != StIdle) && !fifo_empty;
    assign urun_hit    = tick && fifo_empty && ((state_q == StFadeIn) || (state_q == StRun));

    assign gain_sum = {1'b0, gain_q} + 10'(RAMP_STEP);
    assign gain_up  = (gain_sum >= 10'd256) ? 9'd256 : gain_sum[8:0];
    assign gain_dn  = (gain_q > 9'(RAMP_STEP)) ? (gain_q - 9'(RAMP_STEP)) : 9'd0;
    assign to_idle  = (state_q == StFadeOut) && !enable && tick && (gain_dn == 9'd0);

    // Q15 sample times unsigned Q8 gain; bits [23:8] are the arithmetic >>> 8 result.
    assign prod_l      = 26'($signed(cur_l_q)) * 26'($signed({1'b0, gain_q}));
    assign prod_r      = 26'($signed(cur_r_q)) * 26'($signed({1'b0, gain_q}));
    assign unused_prod = ^{prod_l[25:24], prod_l[7:0], prod_r[25:24], prod_r[7:0]};

    assign state       = state_q;
    assign dac_left    = dac_l_q;
    assign dac_right   = dac_r_q;
    assign dac_n_reset = n_reset && dac_n_reset_q;
    assign underrun    = underrun_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            gain_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cur_l_q       <= '0;
            cur_r_q       <= '0;
            dac_l_q       <= 16'h8000;
            dac_r_q       <= 16'h8000;
            dac_upd_q     <= 1'b0;
            dac_n_reset_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            dac_upd_q  <= tick && (state_q != StIdle);

            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q       <= StFadeIn;
                        dac_n_reset_q <= 1'b1;
                        underrun_q    <= 1'b0;
                    end
                end
                StFadeIn: begin
                    if (!enable) begin
                        state_q <= StFadeOut;
                    end else if (tick) begin
                        gain_q <= gain_up;
                        if (gain_up == 9'd256) state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!enable) state_q <= StFadeOut;
                end
                StFadeOut: begin
                    if (enable) begin
                        state_q <= StFadeIn;
                    end else if (tick) begin
                        gain_q <= gain_dn;
                        if (to_idle) begin
                            state_q       <= StIdle;
                            dac_n_reset_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (urun_hit) underrun_q <= 1'b1;

            if (pop) begin
                cur_l_q <= fifo_l_q[rd_ptr_q];
                cur_r_q <= fifo_r_q[rd_ptr_q];
            end

            if ((state_q == StIdle) || to_idle) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_l_q[wr_ptr_q] <= in_left;
                    fifo_r_q[wr_ptr_q] <= in_right;
                    wr_ptr_q           <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end

            // Midscale is forced on the edge that drops dac_n_reset, so the dump sees 8000h.
            if ((state_q == StIdle) || to_idle) begin
                dac_l_q <= 16'h8000;
                dac_r_q <= 16'h8000;
            end else if (dac_upd_q) begin
                dac_l_q <= prod_l[23:8] ^ 16'h8000;
                dac_r_q <= prod_r[23:8] ^ 16'h8000;
            end
        end
    end

`ifdef AUDIO_DAC_SEQ_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            urun_cnt_q <= '0;
        end else if (urun_hit && (urun_cnt_q != 16'hFFFF)) begin
            urun_cnt_q <= urun_cnt_q + 1'b1;
        end
    end

    assign underrun_count = urun_cnt_q;
`endif

endmodule

// File: tb/tb_audio_dac_sequencer.sv
// Self-checking bench for audio_dac_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_audio_dac_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TDIV  = 8;
    localparam int unsigned STEP  = 64;
    localparam int S_IDLE = 0;
    localparam int S_FIN  = 1;
    localparam int S_RUN  = 2;
    localparam int S_FOUT = 3;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic [15:0] dac_left;
    logic [15:0] dac_right;
    logic        dac_n_reset;
    logic        sample_tick;
    logic [1:0]  state;
    logic        underrun;
`ifdef AUDIO_DAC_SEQ_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    audio_dac_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TICK_DIV   (TDIV),
        .RAMP_STEP  (STEP)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .dac_left       (dac_left),
        .dac_right      (dac_right),
        .dac_n_reset    (dac_n_reset),
        .sample_tick    (sample_tick),
        .state          (state),
`ifdef AUDIO_DAC_SEQ_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Behavioural model state
    int          m_state;
    int          m_gain;
    int          m_since;
    int          m_cur_l;
    int          m_cur_r;
    int          m_ucnt;
    logic [15:0] m_dac_l;
    logic [15:0] m_dac_r;
    bit          m_dnr;
    bit          m_urun;
    bit          m_pend;
    logic [31:0] m_fifo[$];

    bit last_ready;
    bit last_tick;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scale by gain/256 with floor rounding, then shift to offset binary.
    function automatic logic [15:0] to_dac(input int smp, input int g);
        int p;
        int q;
        p = smp * g;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return 16'(q + 32768);
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_gain  = 0;
        m_since = 0;
        m_cur_l = 0;
        m_cur_r = 0;
        m_ucnt  = 0;
        m_dac_l = 16'h8000;
        m_dac_r = 16'h8000;
        m_dnr   = 1'b0;
        m_urun  = 1'b0;
        m_pend  = 1'b0;
        m_fifo.delete();
    endtask

    task automatic model_step(input bit en, input bit v, input logic [15:0] l,
                              input logic [15:0] r, input bit nr);
        bit          tk;
        bit          empty;
        bit          acc;
        int          ns;
        int          ng;
        logic [31:0] e;
        if (!nr) begin
            model_reset();
            return;
        end
        tk    = ((m_since % TDIV) == TDIV - 1);
        empty = (m_fifo.size() == 0);
        acc   = v && (m_fifo.size() != DEPTH);
        if (m_pend) begin
            m_dac_l = to_dac(m_cur_l, m_gain);
            m_dac_r = to_dac(m_cur_r, m_gain);
        end
        m_pend = 1'b0;
        ns = m_state;
        ng = m_gain;
        case (m_state)
            S_IDLE: if (en) begin ns = S_FIN; m_urun = 1'b0; end
            S_FIN: begin
                if (!en) ns = S_FOUT;
                else if (tk) begin
                    ng = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                    if (ng == 256) ns = S_RUN;
                end
            end
            S_RUN: if (!en) ns = S_FOUT;
            default: begin
                if (en) ns = S_FIN;
                else if (tk) begin
                    ng = (m_gain - int'(STEP) < 0) ? 0 : m_gain - int'(STEP);
                    if (ng == 0) ns = S_IDLE;
                end
            end
        endcase
        if (m_state != S_IDLE) begin
            if (tk) begin
                m_pend = 1'b1;
                if (!empty) begin
                    e = m_fifo.pop_front();
                    m_cur_l = int'($signed(e[31:16]));
                    m_cur_r = int'($signed(e[15:0]));
                end else if (m_state != S_FOUT) begin
                    m_urun = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (acc) m_fifo.push_back({l, r});
        end
        if (ns == S_IDLE) begin
            m_fifo.delete();
            m_dac_l = 16'h8000;
            m_dac_r = 16'h8000;
        end
        m_state = ns;
        m_gain  = ng;
        m_dnr   = (ns != S_IDLE);
        m_since++;
    endtask

    task automatic step(input bit en, input bit v, input logic [15:0] l, input logic [15:0] r,
                        input bit nr);
        enable   = en;
        in_valid = v;
        in_left  = l;
        in_right = r;
        n_reset  = nr;
        #1;
        last_ready = in_ready;
        last_tick  = sample_tick;
        check_val("in_ready", in_ready, nr && (m_fifo.size() != DEPTH));
        check_val("sample_tick", sample_tick, nr && ((m_since % TDIV) == TDIV - 1));
        check_val("dac_n_reset_pre", dac_n_reset, nr && m_dnr);
        @(posedge clk);
        model_step(en, v, l, r, nr);
        #1;
        check_val("state", state, m_state);
        check_val("dac_left", dac_left, m_dac_l);
        check_val("dac_right", dac_right, m_dac_r);
        check_val("dac_n_reset", dac_n_reset, nr && m_dnr);
        check_val("underrun", underrun, m_urun);
`ifdef AUDIO_DAC_SEQ_UNDERRUN_CNT_EN
        check_val("underrun_count", underrun_count, m_ucnt);
`endif
    endtask

    task automatic run_n(input int n, input bit en, input bit v);
        for (int i = 0; i < n; i++) step(en, v, 16'($urandom), 16'($urandom), 1'b1);
    endtask

    initial begin
        int          ticks;
        int          pushes;
        int          max_jump;
        int          diff;
        int          p;
        bit          en;
        logic [15:0] prev_l;

        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0);

        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
            ticks += int'(last_tick);
        end
        check_val("idle_tick_count", ticks, 5);

        // Start, then load four full-scale pairs before the first tick.
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
        check_val("start_state", state, 1);
        check_val("start_dnr", dac_n_reset, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
        for (int i = 0; i < 60 && m_state != S_RUN; i++) run_n(1, 1'b1, 1'b0);
        run_n(2, 1'b1, 1'b0);
        check_val("run_state", state, 2);
        check_val("run_dac_left", dac_left, 16'hFFFF);
        check_val("run_dac_right", dac_right, 16'h0000);
        check_val("run_underrun", underrun, 0);

        run_n(10, 1'b1, 1'b0);
        check_val("urun_flag", underrun, 1);
        check_val("urun_hold_left", dac_left, 16'hFFFF);

        for (int i = 0; i < 60 && m_state != S_IDLE; i++) run_n(1, 1'b0, 1'b0);
        check_val("stop_state", state, 0);
        check_val("stop_dnr", dac_n_reset, 0);
        check_val("stop_dac_left", dac_left, 16'h8000);
        check_val("stop_dac_right", dac_right, 16'h8000);

        // Reverse direction mid-ramp; output must move by at most one gain step per update.
        max_jump = 0;
        prev_l   = dac_left;
        for (int i = 0; i < 60 && m_gain != 128; i++) begin
            step(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
            diff = int'(dac_left) - int'(prev_l);
            if (diff < 0) diff = -diff;
            if (diff > max_jump) max_jump = diff;
            prev_l = dac_left;
        end
        for (int i = 0; i < 80 && !(m_state == S_RUN && i > 12); i++) begin
            step((i >= 3), 1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
            diff = int'(dac_left) - int'(prev_l);
            if (diff < 0) diff = -diff;
            if (diff > max_jump) max_jump = diff;
            prev_l = dac_left;
        end
        check_val("max_jump_ok", (max_jump <= 32'h2000), 1);

        // Drain, align just after a tick, then hold in_valid high.
        run_n(40, 1'b1, 1'b0);
        for (int i = 0; i < 8 && (m_since % TDIV) != 0; i++) run_n(1, 1'b1, 1'b0);
        pushes = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
            pushes += int'(last_ready);
        end
        check_val("fill_pushes", pushes, 4);
        check_val("full_ready", in_ready, 0);

        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
        check_val("rst_state", state, 0);
        check_val("rst_dac_left", dac_left, 16'h8000);
        check_val("rst_dnr", dac_n_reset, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_ready", in_ready, 0);

        en = 1'b0;
        p  = 50;
        for (int c = 0; c < 2500; c++) begin
            if ((c % 64) == 0) begin
                case ($urandom_range(3))
                    0:       p = 0;
                    1:       p = 30;
                    2:       p = 70;
                    default: p = 100;
                endcase
            end
            if ($urandom_range(49) == 0) en = !en;
            step(en, ($urandom_range(99) < p), 16'($urandom), 16'($urandom),
                 ($urandom_range(399) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
